cic_comb_decim: RTL

CIC_COMB_DECIM -- requirements
Module: cic_comb_decim

---
 rtl/cic_pkg.sv | 32 +++
 rtl/cic_comb_stage.sv | 35 +++
 rtl/cic_comb_decim.sv | 98 +++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared constants and decimation-ratio helpers for the CIC comb/decimator block.
package cic_pkg;

    localparam int ACC_WIDTH_DEF = 28;
    localparam int OUT_WIDTH_DEF = 16;
    localparam int Q_DEF         = 3;

    localparam logic [4:0] DEC_R1  = 5'd1;
    localparam logic [4:0] DEC_R2  = 5'd2;
    localparam logic [4:0] DEC_R4  = 5'd4;
    localparam logic [4:0] DEC_R8  = 5'd8;
    localparam logic [4:0] DEC_R16 = 5'd16;

    // Illegal ratios collapse to R=1.
    function automatic logic [4:0] r_value(input logic [4:0] dec);
        case (dec)
            DEC_R2, DEC_R4, DEC_R8, DEC_R16: return dec;
            default:                         return DEC_R1;
        endcase
    endfunction

    function automatic logic [2:0] r_log2(input logic [4:0] dec);
        case (dec)
            DEC_R2:  return 3'd1;
            DEC_R4:  return 3'd2;
            DEC_R8:  return 3'd3;
            DEC_R16: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered comb section, y = x - x_prev with differential delay 1.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] x,
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] y
);

    logic signed [WIDTH-1:0] x_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            y         <= '0;
            x_prev    <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in)
                y <= x - x_prev;
            // A ratio change restarts the delay line; the output register still lets in-flight data drain.
            if (clear)
                x_prev <= '0;
            else if (valid_in)
                x_prev <= x;
        end
    end

endmodule

// File: rtl/cic_comb_decim.sv
// CIC decimator back end: rate counter, Q comb stages, gain-normalising shift.
// Optional macro CIC_COMB_SAT_EN selects saturating instead of wrapping output reduction.
module cic_comb_decim
    import cic_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int Q         = Q_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic signed [ACC_WIDTH-1:0] comb_in,
    input  logic [4:0]                  dec_factor,
    output logic signed [OUT_WIDTH-1:0] comb_out,
    output logic                        valid_out
);

    logic [4:0] dec_reg;
    logic [4:0] count;
    logic [4:0] r_eff;
    logic       cfg_change;
    logic       strobe;
    logic [7:0] shamt;

    logic signed [ACC_WIDTH-1:0] stg_x [0:Q];
    logic                        stg_v [0:Q];
    logic signed [OUT_WIDTH-1:0] reduced;

    assign cfg_change = (dec_factor != dec_reg);
    assign r_eff      = r_value(dec_reg);
    // A valid_in landing in the ratio-change cycle is dropped; counting restarts cleanly afterwards.
    assign strobe     = valid_in && !cfg_change && (count == r_eff - 5'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_reg <= '0;
            count   <= '0;
        end else begin
            dec_reg <= dec_factor;
            if (cfg_change)
                count <= '0;
            else if (valid_in)
                count <= strobe ? 5'd0 : count + 5'd1;
        end
    end

    assign stg_x[0] = comb_in;
    assign stg_v[0] = strobe;

    genvar k;
    generate
        for (k = 0; k < Q; k++) begin : g_stage
            cic_comb_stage #(.WIDTH(ACC_WIDTH)) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .clear     (cfg_change),
                .valid_in  (stg_v[k]),
                .x         (stg_x[k]),
                .valid_out (stg_v[k+1]),
                .y         (stg_x[k+1])
            );
        end
    endgenerate

    assign shamt = 8'(Q) * 8'(r_log2(dec_reg));

`ifdef CIC_COMB_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_WIDTH-1:0] shifted;
    assign shifted = stg_x[Q] >>> shamt;

    always_comb begin
        reduced = shifted[OUT_WIDTH-1:0];
        if (shifted > SAT_MAX)
            reduced = SAT_MAX[OUT_WIDTH-1:0];
        else if (shifted < SAT_MIN)
            reduced = SAT_MIN[OUT_WIDTH-1:0];
    end
`else
    assign reduced = OUT_WIDTH'(stg_x[Q] >>> shamt);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comb_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= stg_v[Q];
            if (stg_v[Q])
                comb_out <= reduced;
        end
    end

endmodule
